// File: rtl/gpio_apb_cfg_pkg.sv
// Shared types and helpers for the GPIO APB configuration initiator.
// No timing of its own: enums, register indices and pure functions only.
// No flow control here; users apply these in their own handshakes.
package gpio_apb_cfg_pkg;

  // Transfer sequencing: command wait, APB setup, APB access, response hold.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Response status codes returned with every command.
  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_SLVERR  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ILLEGAL = 2'b11
  } err_e;

  // GPIO responder register map, as word indices.
  localparam logic [3:0] GPIO_PADDIR    = 4'd0;
  localparam logic [3:0] GPIO_PADIN     = 4'd1;
  localparam logic [3:0] GPIO_PADOUT    = 4'd2;
  localparam logic [3:0] GPIO_INTEN     = 4'd3;
  localparam logic [3:0] GPIO_INTTYPE0  = 4'd4;
  localparam logic [3:0] GPIO_INTTYPE1  = 4'd5;
  localparam logic [3:0] GPIO_INTSTATUS = 4'd6;
  localparam logic [3:0] GPIO_IOFCFG    = 4'd7;

  // Indices past the map are rejected; PADIN and INTSTATUS are read-only.
  function automatic logic is_legal(input logic write, input logic [3:0] idx);
    if (idx > GPIO_IOFCFG) begin
      return 1'b0;
    end
    if (write && (idx == GPIO_PADIN || idx == GPIO_INTSTATUS)) begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Low n bits set; a full 32-pin build keeps every bit.
  function automatic logic [31:0] data_mask(input int unsigned n);
    if (n >= 32) begin
      return '1;
    end
    return (32'h1 << n) - 32'h1;
  endfunction

endpackage

// File: rtl/gpio_apb_cfg_master.sv
// APB4 initiator running one GPIO register read/write per accepted command.
// Latency: accept N, SETUP N+1, ACCESS N+2.., rsp_valid one cycle after pready (or timeout).
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
module gpio_apb_cfg_master
  import gpio_apb_cfg_pkg::*;
#(
  parameter int GPIO_NUM    = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [3:0]  cmd_reg_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic [31:0] paddr_o,
  output logic [2:0]  pprot_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  localparam logic [31:0] MASK      = data_mask(GPIO_NUM);
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_SETUP  = S_SETUP;
  localparam logic [1:0] ST_ACCESS = S_ACCESS;
  localparam logic [1:0] ST_RESP   = S_RESP;

  logic [1:0]  state;
  logic        cap_write;
  logic [3:0]  cap_idx;
  logic [31:0] cap_wdata;
  logic [15:0] cnt;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;
  logic        bus_active;

  // Sequencer, command capture, wait-state counter and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready is high whenever IDLE is reached out of reset.
          if (cmd_valid_i) begin
            cap_write <= cmd_write_i;
            cap_idx   <= cmd_reg_i;
            cap_wdata <= cmd_wdata_i & MASK;
            rdata_q   <= '0;
            if (is_legal(cmd_write_i, cmd_reg_i)) begin
              state <= ST_SETUP;
            end else begin
              // Rejected commands never touch the bus.
              err_q <= ERR_ILLEGAL;
              state <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready is checked first so it wins on the terminal count cycle.
          if (pready_i) begin
            rdata_q <= (!cap_write && !pslverr_i) ? (prdata_i & MASK) : '0;
            err_q   <= pslverr_i ? ERR_SLVERR : ERR_OK;
            state   <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= ERR_TIMEOUT;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_active = (state == ST_SETUP) || (state == ST_ACCESS);

  // Gate with rst_i so no command is taken while reset is still asserted.
  assign cmd_ready_o = (state == ST_IDLE) && !rst_i;

  // Bus fields are driven only while a transfer is on the wire, zero otherwise.
  assign psel_o    = bus_active;
  assign penable_o = (state == ST_ACCESS);
  assign pwrite_o  = bus_active && cap_write;
  assign paddr_o   = bus_active ? {26'b0, cap_idx, 2'b00} : 32'h0;
  assign pwdata_o  = bus_active ? cap_wdata : 32'h0;
  assign pstrb_o   = (bus_active && cap_write) ? 4'hF : 4'h0;
  assign pprot_o   = 3'b000;

  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
  assign rsp_err_o   = rsp_valid_o ? err_q : 2'b00;

endmodule

// File: tb/tb_gpio_apb_cfg_master.sv
// Directed bench for the GPIO APB initiator with a transaction-level expectation model.
// Stimulus tasks derive per-cycle expected outputs from each command; one process compares.
// Responder wait states, errors, timeouts, response stalls and mid-transfer reset are exercised.
module tb_gpio_apb_cfg_master;

  localparam int          TO   = 16;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_reg;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  always #5 clk = ~clk;

  gpio_apb_cfg_master #(.GPIO_NUM(8), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_reg_i(cmd_reg), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Expected outputs for the current cycle.
  logic        e_chk = 1'b0;
  logic        e_cmd_ready, e_rsp_valid, e_psel, e_penable, e_pwrite;
  logic [31:0] e_rdata, e_paddr, e_pwdata;
  logic [1:0]  e_err;
  logic [3:0]  e_pstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model, away from the rising edge.
  always @(negedge clk) begin
    if (e_chk) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err",   32'(rsp_err), 32'(e_err));
      chk("psel",      32'(psel), 32'(e_psel));
      chk("penable",   32'(penable), 32'(e_penable));
      chk("pwrite",    32'(pwrite), 32'(e_pwrite));
      chk("paddr",     paddr, e_paddr);
      chk("pwdata",    pwdata, e_pwdata);
      chk("pstrb",     32'(pstrb), 32'(e_pstrb));
      chk("pprot",     32'(pprot), 32'h0);
    end
  end

  // Observations of DUT behaviour, pinned against hand-computed literals.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          obs_lat = 0;
  int          obs_pen = 0;
  logic        obs_psel_seen = 1'b0;
  logic        lat_done = 1'b0;
  logic [31:0] obs_rdata = 32'h0;
  logic [1:0]  obs_err = 2'b00;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cyc       <= cyc;
      obs_pen       <= 0;
      obs_psel_seen <= 1'b0;
      lat_done      <= 1'b0;
    end else begin
      if (penable) obs_pen <= obs_pen + 1;
      if (psel) obs_psel_seen <= 1'b1;
      if (rsp_valid && !lat_done) begin
        obs_lat   <= cyc - acc_cyc;
        lat_done  <= 1'b1;
        obs_rdata <= rsp_rdata;
        obs_err   <= rsp_err;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle(input logic rdy);
    e_cmd_ready = rdy; e_rsp_valid = 1'b0; e_rdata = '0; e_err = '0;
    e_psel = 1'b0; e_penable = 1'b0; e_pwrite = 1'b0;
    e_paddr = '0; e_pwdata = '0; e_pstrb = '0;
  endtask

  task automatic exp_bus(input logic en, input logic w, input logic [3:0] idx, input logic [31:0] wd);
    exp_idle(1'b0);
    e_psel = 1'b1; e_penable = en; e_pwrite = w;
    e_paddr = {26'b0, idx, 2'b00};
    e_pwdata = wd & MASK;
    e_pstrb = w ? 4'hF : 4'h0;
  endtask

  task automatic exp_resp(input logic [31:0] rd, input logic [1:0] er);
    exp_idle(1'b0);
    e_rsp_valid = 1'b1; e_rdata = rd; e_err = er;
  endtask

  // One command end to end. waits < 0 means the responder never answers.
  task automatic run_cmd(input logic w, input logic [3:0] idx, input logic [31:0] wd,
                         input int waits, input logic [31:0] prd, input logic slv, input int stall);
    logic        legal;
    int          n_acc;
    logic [1:0]  er;
    logic [31:0] rd;
    legal = (idx <= 4'd7) && !(w && (idx == 4'd1 || idx == 4'd6));
    tick();
    cmd_valid = 1'b1; cmd_write = w; cmd_reg = idx; cmd_wdata = wd;
    pready = 1'b0; prdata = '0; pslverr = 1'b0; rsp_ready = 1'b0;
    exp_idle(1'b1);
    if (legal) begin
      tick();
      cmd_valid = 1'b0;
      exp_bus(1'b0, w, idx, wd);
      n_acc = (waits < 0) ? TO : waits + 1;
      for (int k = 0; k < n_acc; k++) begin
        tick();
        exp_bus(1'b1, w, idx, wd);
        pready  = (waits >= 0) && (k == waits);
        prdata  = pready ? prd : 32'hDEAD_BEEF;
        pslverr = pready && slv;
      end
      er = (waits < 0) ? 2'b10 : (slv ? 2'b01 : 2'b00);
      rd = (!w && waits >= 0 && !slv) ? (prd & MASK) : 32'h0;
    end else begin
      er = 2'b11;
      rd = 32'h0;
    end
    for (int s = 0; s <= stall; s++) begin
      tick();
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      rsp_ready = (s == stall);
      cmd_valid = (s < stall);
      cmd_write = 1'b1; cmd_reg = 4'd0; cmd_wdata = 32'hFFFF_FFFF;
      exp_resp(rd, er);
    end
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    exp_idle(1'b1);
  endtask

  // Reset asserted while a read sits in ACCESS waiting on the responder.
  task automatic reset_mid_access();
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = 4'd2; cmd_wdata = '0;
    exp_idle(1'b1);
    tick();
    cmd_valid = 1'b0;
    exp_bus(1'b0, 1'b0, 4'd2, 32'h0);
    tick();
    exp_bus(1'b1, 1'b0, 4'd2, 32'h0);
    tick();
    rst = 1'b1;
    exp_bus(1'b1, 1'b0, 4'd2, 32'h0);
    tick();
    exp_idle(1'b0);
    tick();
    rst = 1'b0;
    exp_idle(1'b1);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_reg = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    exp_idle(1'b0);
    tick();
    e_chk = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_idle(1'b1);
    tick();

    // Write PADDIR, zero-wait responder.
    run_cmd(1'b1, 4'd0, 32'hFFFF_00A5, 0, 32'h0, 1'b0, 0);
    chk("t1_latency", 32'(obs_lat), 32'd3);
    chk("t1_access_cycles", 32'(obs_pen), 32'd1);
    chk("t1_err", 32'(obs_err), 32'd0);

    // Read PADIN with three wait states.
    run_cmd(1'b0, 4'd1, 32'h0, 3, 32'h1234_5678, 1'b0, 0);
    chk("t2_rdata", obs_rdata, 32'h0000_0078);
    chk("t2_access_cycles", 32'(obs_pen), 32'd4);
    chk("t2_latency", 32'(obs_lat), 32'd6);

    // Illegal write to INTSTATUS, then illegal read beyond the map.
    run_cmd(1'b1, 4'd6, 32'h0000_00FF, 0, 32'h0, 1'b0, 0);
    chk("t3_latency", 32'(obs_lat), 32'd1);
    chk("t3_err", 32'(obs_err), 32'd3);
    chk("t3_psel_seen", 32'(obs_psel_seen), 32'd0);
    run_cmd(1'b0, 4'd9, 32'h0, 0, 32'h0, 1'b0, 0);
    chk("t4_err", 32'(obs_err), 32'd3);
    chk("t4_rdata", obs_rdata, 32'h0);
    chk("t4_psel_seen", 32'(obs_psel_seen), 32'd0);

    // Responder never answers: timeout, then a normal read.
    run_cmd(1'b0, 4'd2, 32'h0, -1, 32'h0, 1'b0, 0);
    chk("t5_access_cycles", 32'(obs_pen), 32'd16);
    chk("t5_err", 32'(obs_err), 32'd2);
    run_cmd(1'b0, 4'd2, 32'h0, 0, 32'h0000_0155, 1'b0, 0);
    chk("t6_rdata", obs_rdata, 32'h0000_0055);

    // SLVERR read with a five-cycle response stall and commands offered meanwhile.
    run_cmd(1'b0, 4'd3, 32'h0, 1, 32'hAAAA_5A5A, 1'b1, 5);
    chk("t7_err", 32'(obs_err), 32'd1);
    chk("t7_rdata", obs_rdata, 32'h0);
    chk("t7_latency", 32'(obs_lat), 32'd4);

    // pready arrives on the terminal-count cycle: the transfer completes.
    run_cmd(1'b0, 4'd4, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 0);
    chk("t8_err", 32'(obs_err), 32'd0);
    chk("t8_rdata", obs_rdata, 32'h0000_000D);
    chk("t8_access_cycles", 32'(obs_pen), 32'd16);

    // Legal write to IOFCFG with wait states, read of INTSTATUS.
    run_cmd(1'b1, 4'd7, 32'h1234_5633, 2, 32'h0, 1'b0, 1);
    run_cmd(1'b0, 4'd6, 32'h0, 0, 32'h8000_0081, 1'b0, 0);
    chk("t10_rdata", obs_rdata, 32'h0000_0081);

    // Reset in ACCESS drops the command; the next read works normally.
    reset_mid_access();
    run_cmd(1'b0, 4'd5, 32'h0, 0, 32'h0000_003C, 1'b0, 0);
    chk("t11_rdata", obs_rdata, 32'h0000_003C);
    chk("t11_latency", 32'(obs_lat), 32'd3);

    @(negedge clk);
    #1;
    e_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_apb_cfg_master.md
Name: gpio_apb_cfg_master

Overview:
- APB4 initiator that programs and reads the GPIO register map (PADDIR, PADIN, PADOUT, INTEN, INTTYPE0, INTTYPE1, INTSTATUS, IOFCFG) on behalf of a local controller: boot sequencer, debug bridge or bench agent.
- Accepts one register command at a time over valid/ready, runs one APB4 transfer, and returns data plus status over valid/ready.
- Sits on the bus side opposite the GPIO responder.

Parameters:
- GPIO_NUM, 8, implemented pin count; write data and read data are masked to bits [GPIO_NUM-1:0].
- TIMEOUT_CYC, 256, maximum ACCESS cycles waiting for pready before abort; range 2..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_reg_i  in  4  register index; the byte address is {26'b0, idx, 2'b00}
- cmd_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data, masked; 0 for writes and errors
- rsp_err_o  out  2  00 OK, 01 SLVERR, 10 TIMEOUT, 11 ILLEGAL
- paddr_o  out  32  APB address
- pprot_o  out  3  fixed 3'b000
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  32  APB write data
- pstrb_o  out  4  4'hF on writes, 4'h0 on reads
- pready_i  in  1  APB ready
- prdata_i  in  32  APB read data
- pslverr_i  in  1  APB error

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready_o (0 during reset, 1 the first cycle after). State is IDLE. Timeout counter is 0.
- States are IDLE, SETUP, ACCESS, RESP.
  - cmd_ready_o = (state == IDLE).
- IDLE: on cmd_valid_i & cmd_ready_o, capture write, index and wdata & mask.
  - Legality check: index > 7 is illegal. A write to index 1 (PADIN) or 6 (INTSTATUS) is illegal.
  - Illegal: go to RESP with err 11 and no bus activity.
  - Legal: go to SETUP.
- SETUP (one cycle): psel_o = 1, penable_o = 0. paddr, pwrite, pwdata and pstrb are driven from the captured command. Next state is ACCESS.
- ACCESS: psel_o = 1, penable_o = 1. paddr, pwrite and pwdata stay stable.
  - If pready_i: capture prdata_i & mask (reads only), set err = pslverr_i ? 01 : 00, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC-1 with pready_i still low: err 10, rdata 0, go to RESP.
- Bus return after ACCESS: psel_o and penable_o drop to 0 in the cycle after ACCESS completes, by either pready or timeout. pwdata_o and paddr_o return to 0 in IDLE and RESP.
- RESP: rsp_valid_o = 1. rsp_rdata_o and rsp_err_o are held until rsp_ready_i; they are stable under backpressure. On handshake, go to IDLE and clear the counter.
- Read data on SLVERR is forced to 0.
- Latency with a zero-wait responder: command accepted at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3. Throughput is one command per 4 cycles when rsp_ready_i is held high.
- The mask is ((1 << GPIO_NUM) - 1) when GPIO_NUM < 32, and all ones when GPIO_NUM = 32.
- Simultaneous events:
  - pready_i and the timeout terminal count in the same cycle: pready wins.
  - cmd_valid_i during RESP: ignored, because cmd_ready_o is 0.
- Reset mid-operation: the bus is released immediately (psel and penable are 0 the next cycle). The in-flight command is dropped with no response.

Decomposition:
- Package gpio_apb_cfg_pkg holds:
  - state enum;
  - err enum (OK, SLVERR, TIMEOUT, ILLEGAL);
  - register index constants matching the GPIO_* map;
  - function is_legal(write, idx).
- No sub-module. The FSM, capture registers and timeout counter all live in one module (150-250 lines).

Test Plan:
- Write PADDIR idx 0, wdata 32'hFFFF_00A5, zero-wait responder -> paddr 0x00, pwdata 0x0000_00A5, pstrb F, SETUP/ACCESS each 1 cycle, rsp err 00 at accept+3.
- Read PADIN idx 1, prdata 32'h1234_5678, 3 wait states -> penable held 4 cycles with address stable, rsp_rdata 0x0000_0078, err 00.
- Write INTSTATUS idx 6, and separately read idx 9 -> no psel ever, rsp err 11 at accept+1, rdata 0.
- pready tied low, TIMEOUT_CYC = 16 -> ACCESS lasts exactly 16 cycles, psel drops, err 10. A following read of idx 2 then completes normally.
- pslverr with pready on a read of idx 3 -> err 01, rdata 0. rsp_ready held low for 5 cycles -> response stable, cmd_ready 0 throughout.
- Assert rst_i during ACCESS -> psel/penable 0 next cycle, no rsp_valid, cmd_ready 1 the cycle after reset deasserts.
